// File: rtl/mem_bus_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_bus_access_unit
// Brief    : MEM-stage load/store unit issuing one req/ack bus transaction per access.
// Revision : 1.0
// ============================================================================
module mem_bus_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int BIG_ENDIAN     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [3:0]        op_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       reg2_i,
    input  logic              flush_i,
    input  logic              llclr_i,
    output logic              stallreq_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              bus_fault_o,
    output logic              llbit_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic              bus_err_i,
    input  logic [31:0]       bus_rdata_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [3:0] c_OP_LB  = 4'd0;
    localparam logic [3:0] c_OP_LBU = 4'd1;
    localparam logic [3:0] c_OP_LH  = 4'd2;
    localparam logic [3:0] c_OP_LHU = 4'd3;
    localparam logic [3:0] c_OP_LW  = 4'd4;
    localparam logic [3:0] c_OP_SB  = 4'd5;
    localparam logic [3:0] c_OP_SH  = 4'd6;
    localparam logic [3:0] c_OP_SW  = 4'd7;
    localparam logic [3:0] c_OP_LL  = 4'd8;
    localparam logic [3:0] c_OP_SC  = 4'd9;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUS   = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_op;
    logic [1:0]       r_lo;
    logic             r_llbit;

    logic             w_legal, w_store, w_byte_op, w_half_op, w_misalign;
    logic [1:0]       w_req_lane;
    logic             w_req_hi;
    logic [3:0]       w_sel;
    logic [31:0]      w_wdata;
    logic [1:0]       w_rsp_lane;
    logic             w_rsp_hi;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ld;
    logic             w_tmo, w_bus_end, w_ack_ok;

    // Request decode straight from the held pipeline inputs
    always_comb begin
        w_legal    = (op_i <= c_OP_SC);
        w_store    = op_i inside {c_OP_SB, c_OP_SH, c_OP_SW, c_OP_SC};
        w_byte_op  = op_i inside {c_OP_LB, c_OP_LBU, c_OP_SB};
        w_half_op  = op_i inside {c_OP_LH, c_OP_LHU, c_OP_SH};
        w_misalign = (w_half_op & mem_addr_i[0]) |
                     (~w_byte_op & ~w_half_op & (|mem_addr_i[1:0]));
        w_req_lane = (BIG_ENDIAN != 0) ? ~mem_addr_i[1:0] : mem_addr_i[1:0];
        w_req_hi   = (BIG_ENDIAN != 0) ? ~mem_addr_i[1] : mem_addr_i[1];
        if (w_byte_op) begin
            w_sel   = 4'b0001 << w_req_lane;
            w_wdata = {4{reg2_i[7:0]}};
        end else if (w_half_op) begin
            w_sel   = w_req_hi ? 4'b1100 : 4'b0011;
            w_wdata = {2{reg2_i[15:0]}};
        end else begin
            w_sel   = 4'b1111;
            w_wdata = reg2_i;
        end
    end

    // Response path uses the op/offset latched at accept time
    always_comb begin
        w_rsp_lane = (BIG_ENDIAN != 0) ? ~r_lo : r_lo;
        w_rsp_hi   = (BIG_ENDIAN != 0) ? ~r_lo[1] : r_lo[1];
        w_byte     = bus_rdata_i[{w_rsp_lane, 3'b000} +: 8];
        w_half     = w_rsp_hi ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (r_op)
            c_OP_LB:         w_ld = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU:        w_ld = {24'd0, w_byte};
            c_OP_LH:         w_ld = {{16{w_half[15]}}, w_half};
            c_OP_LHU:        w_ld = {16'd0, w_half};
            c_OP_LW, c_OP_LL: w_ld = bus_rdata_i;
            c_OP_SC:         w_ld = 32'd1;
            default:         w_ld = 32'd0;
        endcase
    end

    assign w_tmo     = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign w_bus_end = bus_err_i | bus_ack_i | w_tmo;
    assign w_ack_ok  = (r_state == c_BUS) && bus_ack_i && !bus_err_i && !flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_lo        <= '0;
            done_o      <= 1'b0;
            rdata_o     <= '0;
            adel_o      <= 1'b0;
            ades_o      <= 1'b0;
            bus_fault_o <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= '0;
            bus_wdata_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (req_valid_i && w_legal && !flush_i) begin
                        r_op <= op_i;
                        r_lo <= mem_addr_i[1:0];
                        if (w_misalign || (op_i == c_OP_SC && !r_llbit)) begin
                            r_state     <= c_DONE;
                            done_o      <= 1'b1;
                            rdata_o     <= '0;
                            adel_o      <= w_misalign & ~w_store;
                            ades_o      <= w_misalign & w_store;
                            bus_fault_o <= 1'b0;
                        end else begin
                            r_state     <= c_BUS;
                            r_cnt       <= '0;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= w_store;
                            bus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                            bus_sel_o   <= w_sel;
                            bus_wdata_o <= w_wdata;
                        end
                    end
                end
                c_BUS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_bus_end) begin
                        bus_req_o <= 1'b0;
                        r_cnt     <= '0;
                        if (flush_i) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_state     <= c_DONE;
                            done_o      <= 1'b1;
                            adel_o      <= 1'b0;
                            ades_o      <= 1'b0;
                            // Error beats a simultaneous ack; a bare timeout also lands here
                            bus_fault_o <= bus_err_i | ~bus_ack_i;
                            rdata_o     <= (bus_ack_i && !bus_err_i) ? w_ld : 32'd0;
                        end
                    end else if (flush_i) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_bus_end) begin
                        bus_req_o <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= c_IDLE;
                    end
                end
                c_DONE: begin
                    r_state     <= c_IDLE;
                    adel_o      <= 1'b0;
                    ades_o      <= 1'b0;
                    bus_fault_o <= 1'b0;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Clear (ERET or a completed SC) takes priority over an LL setting the link
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_llbit <= 1'b0;
        end else if (llclr_i || (w_ack_ok && r_op == c_OP_SC)) begin
            r_llbit <= 1'b0;
        end else if (w_ack_ok && r_op == c_OP_LL) begin
            r_llbit <= 1'b1;
        end
    end

    assign llbit_o    = r_llbit;
    assign stallreq_o = req_valid_i & ~done_o & w_legal;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_access_unit
// Brief    : Self-checking bench with a behavioural bus slave and access model.
// Revision : 1.0
// ============================================================================
module tb_mem_bus_access_unit;

    localparam int TMO = 4;
    localparam logic [3:0] OP_LB = 4'd0, OP_LBU = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3,
                           OP_LW = 4'd4, OP_SB = 4'd5, OP_SH = 4'd6, OP_SW = 4'd7,
                           OP_LL = 4'd8, OP_SC = 4'd9;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, flush_i, llclr_i;
    logic [3:0]  op_i;
    logic [31:0] mem_addr_i, reg2_i;
    logic        stallreq_o, done_o, adel_o, ades_o, bus_fault_o, llbit_o;
    logic [31:0] rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i, bus_err_i;
    logic [31:0] bus_rdata_i;

    int n_cmp = 0;
    int n_bad = 0;
    bit link_m = 1'b0;

    always #5 clk = ~clk;

    mem_bus_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO), .BIG_ENDIAN(1)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .op_i(op_i),
        .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .flush_i(flush_i), .llclr_i(llclr_i),
        .stallreq_o(stallreq_o), .done_o(done_o), .rdata_o(rdata_o), .adel_o(adel_o),
        .ades_o(ades_o), .bus_fault_o(bus_fault_o), .llbit_o(llbit_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
        .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i)
    );

    // Drives one access and plays the slave: ack/err after wait_n request cycles.
    // Cycle numbers are relative to the accept cycle N (k = 0).
    task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int wait_n, input bit berr, input bit clr_on_ack,
                          input logic [31:0] bdata,
                          output int done_k, output int req_k, output int req_cnt,
                          output logic [3:0] sel, output logic we, output logic [31:0] baddr,
                          output logic [31:0] bwd, output logic [31:0] rd,
                          output logic [2:0] flags, output int stall_err);
        done_k = -1; req_k = -1; req_cnt = 0; sel = '0; we = 1'b0; baddr = '0; bwd = '0;
        rd = '0; flags = '0; stall_err = 0;
        @(negedge clk);
        req_valid_i = 1'b1; op_i = op; mem_addr_i = addr; reg2_i = wd; bus_rdata_i = bdata;
        #1 if (stallreq_o !== 1'b1) stall_err++;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus_ack_i = 1'b0; bus_err_i = 1'b0; llclr_i = 1'b0;
            if (bus_req_o === 1'b1) begin
                if (req_k < 0) begin
                    req_k = k; sel = bus_sel_o; we = bus_we_o; baddr = bus_addr_o; bwd = bus_wdata_o;
                end
                if (req_cnt == wait_n) begin
                    if (berr) bus_err_i = 1'b1; else bus_ack_i = 1'b1;
                    llclr_i = clr_on_ack;
                end
                req_cnt++;
            end
            if (done_o === 1'b1) begin
                done_k = k; rd = rdata_o; flags = {adel_o, ades_o, bus_fault_o};
                if (stallreq_o !== 1'b0) stall_err++;
                break;
            end
            if (stallreq_o !== 1'b1) stall_err++;
        end
        req_valid_i = 1'b0; bus_ack_i = 1'b0; bus_err_i = 1'b0; llclr_i = 1'b0;
    endtask

    // Reference model: what one access should look like, big-endian lanes, TMO timeout.
    task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input int w, input bit berr, input logic [31:0] bdata,
                         output int e_done, output int e_req_k, output int e_req_cnt,
                         output logic [3:0] e_sel, output logic e_we, output logic [31:0] e_baddr,
                         output logic [31:0] e_bwd, output logic [31:0] e_rd,
                         output logic [2:0] e_flags);
        int size, o, shift;
        bit store;
        logic [63:0] mask;
        logic [31:0] v;
        size  = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
                (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
        store = (op == OP_SB || op == OP_SH || op == OP_SW || op == OP_SC);
        o     = int'(addr % 4);
        e_done = 1; e_req_k = -1; e_req_cnt = 0; e_sel = '0; e_we = 1'b0; e_baddr = '0;
        e_bwd = '0; e_rd = '0; e_flags = '0;
        if (o % size != 0) begin
            e_flags = store ? 3'b010 : 3'b100;
        end else if (op == OP_SC && !link_m) begin
            e_rd = 32'd0;
        end else begin
            e_req_k = 1; e_we = store; e_baddr = addr & ~32'd3;
            shift   = (4 - o - size) * 8;
            mask    = (64'd1 << (8 * size)) - 64'd1;
            e_sel   = 4'(((1 << size) - 1) << (4 - o - size));
            e_bwd   = (size == 1) ? (wd & 32'hFF) * 32'h01010101 :
                      (size == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
            if (berr || w > TMO) begin
                e_flags   = 3'b001;
                e_req_cnt = (w > TMO) ? TMO + 1 : w + 1;
                e_done    = 2 + ((w > TMO) ? TMO : w);
            end else begin
                e_req_cnt = w + 1;
                e_done    = 2 + w;
                v = (bdata >> shift) & mask[31:0];
                if (op == OP_LB && v[7])  v = v | 32'hFFFFFF00;
                if (op == OP_LH && v[15]) v = v | 32'hFFFF0000;
                if (store) v = 32'd0;
                if (op == OP_SC) begin v = 32'd1; link_m = 1'b0; end
                if (op == OP_LL) link_m = 1'b1;
                e_rd = v;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid_i = 1'b0; flush_i = 1'b0; llclr_i = 1'b0; op_i = '0;
        mem_addr_i = '0; reg2_i = '0; bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({done_o, adel_o, ades_o, bus_fault_o, llbit_o, stallreq_o} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000000",
                              {done_o, adel_o, ades_o, bus_fault_o, llbit_o, stallreq_o});
        end
        n_cmp++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o} !== 70'b0) begin
            n_bad++; $display("FAIL reset_bus: got req=%b we=%b addr=%h sel=%b wdata=%h want zeros",
                              bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o);
        end
        n_cmp++;
        if (rdata_o !== 32'd0) begin
            n_bad++; $display("FAIL reset_rdata: got %h want 00000000", rdata_o);
        end
        rst = 1'b1;
        link_m = 1'b0;
    endtask

    task automatic test_load_store();
        int dk, rk, rc, se;
        logic [3:0] sel; logic we; logic [31:0] ba, bw, rd; logic [2:0] fl;
        access(OP_LW, 32'h100, 32'h0, 0, 1'b0, 1'b0, 32'hDEADBEEF, dk, rk, rc, sel, we, ba, bw, rd, fl, se);
        n_cmp++;
        if ({8'(dk), 8'(rk), sel, ba, rd, fl, 8'(se)} !== {8'd2, 8'd1, 4'b1111, 32'h100, 32'hDEADBEEF, 3'b000, 8'd0}) begin
            n_bad++; $display("FAIL lw_zero_wait: got done=%0d req=%0d sel=%b addr=%h rdata=%h flags=%b stallerr=%0d want 2 1 1111 100 deadbeef 000 0",
                              dk, rk, sel, ba, rd, fl, se);
        end
        access(OP_LB, 32'h103, 32'h0, 0, 1'b0, 1'b0, 32'h000000F0, dk, rk, rc, sel, we, ba, bw, rd, fl, se);
        n_cmp++;
        if ({sel, rd} !== {4'b0001, 32'hFFFFFFF0}) begin
            n_bad++; $display("FAIL lb_sign: got sel=%b rdata=%h want 0001 fffffff0", sel, rd);
        end
        access(OP_LBU, 32'h103, 32'h0, 0, 1'b0, 1'b0, 32'h000000F0, dk, rk, rc, sel, we, ba, bw, rd, fl, se);
        n_cmp++;
        if ({sel, rd} !== {4'b0001, 32'h000000F0}) begin
            n_bad++; $display("FAIL lbu_zero: got sel=%b rdata=%h want 0001 000000f0", sel, rd);
        end
        access(OP_SH, 32'h101, 32'h1234, 0, 1'b0, 1'b0, 32'h0, dk, rk, rc, sel, we, ba, bw, rd, fl, se);
        n_cmp++;
        if ({8'(dk), 8'(rk), fl} !== {8'd1, 8'hFF, 3'b010}) begin
            n_bad++; $display("FAIL sh_misaligned: got done=%0d req=%0d flags=%b want 1 -1 010", dk, rk, fl);
        end
    endtask

    task automatic test_ll_sc();
        int dk, rk, rc, se;
        logic [3:0] sel; logic we; logic [31:0] ba, bw, rd; logic [2:0] fl;
        access(OP_LL, 32'h200, 32'h0, 1, 1'b0, 1'b0, 32'h55AA55AA, dk, rk, rc, sel, we, ba, bw, rd, fl, se);
        n_cmp++;
        if ({8'(dk), rd, llbit_o} !== {8'd3, 32'h55AA55AA, 1'b1}) begin
            n_bad++; $display("FAIL ll_link: got done=%0d rdata=%h llbit=%b want 3 55aa55aa 1", dk, rd, llbit_o);
        end
        access(OP_SC, 32'h200, 32'hCAFEF00D, 0, 1'b0, 1'b0, 32'h0, dk, rk, rc, sel, we, ba, bw, rd, fl, se);
        n_cmp++;
        if ({8'(rk), we, sel, bw, rd, llbit_o} !== {8'd1, 1'b1, 4'b1111, 32'hCAFEF00D, 32'd1, 1'b0}) begin
            n_bad++; $display("FAIL sc_ok: got req=%0d we=%b sel=%b wdata=%h rdata=%h llbit=%b want 1 1 1111 cafef00d 1 0",
                              rk, we, sel, bw, rd, llbit_o);
        end
        access(OP_SC, 32'h200, 32'hCAFEF00D, 0, 1'b0, 1'b0, 32'h0, dk, rk, rc, sel, we, ba, bw, rd, fl, se);
        n_cmp++;
        if ({8'(dk), 8'(rk), rd} !== {8'd1, 8'hFF, 32'd0}) begin
            n_bad++; $display("FAIL sc_fail: got done=%0d req=%0d rdata=%h want 1 -1 0", dk, rk, rd);
        end
        // LL whose ack coincides with llclr: clear must win
        access(OP_LL, 32'h204, 32'h0, 0, 1'b0, 1'b1, 32'h1, dk, rk, rc, sel, we, ba, bw, rd, fl, se);
        n_cmp++;
        if (llbit_o !== 1'b0) begin
            n_bad++; $display("FAIL ll_clr_race: got llbit=%b want 0", llbit_o);
        end
        link_m = 1'b0;
    endtask

    task automatic test_timeout();
        int dk, rk, rc, se;
        logic [3:0] sel; logic we; logic [31:0] ba, bw, rd; logic [2:0] fl;
        access(OP_LW, 32'h400, 32'h0, 100, 1'b0, 1'b0, 32'h0, dk, rk, rc, sel, we, ba, bw, rd, fl, se);
        n_cmp++;
        if ({8'(dk), 8'(rc), fl} !== {8'd6, 8'd5, 3'b001}) begin
            n_bad++; $display("FAIL timeout: got done=%0d reqcycles=%0d flags=%b want 6 5 001", dk, rc, fl);
        end
        access(OP_LW, 32'h404, 32'h0, 0, 1'b0, 1'b0, 32'h600DF00D, dk, rk, rc, sel, we, ba, bw, rd, fl, se);
        n_cmp++;
        if ({8'(dk), rd, fl} !== {8'd2, 32'h600DF00D, 3'b000}) begin
            n_bad++; $display("FAIL after_timeout: got done=%0d rdata=%h flags=%b want 2 600df00d 000", dk, rd, fl);
        end
    endtask

    task automatic test_flush();
        int reqs, dones, stall_hi, dk, rk, rc, se;
        logic [3:0] sel; logic we; logic [31:0] ba, bw, rd; logic [2:0] fl;
        reqs = 0; dones = 0; stall_hi = 0;
        @(negedge clk);
        llclr_i = 1'b1;
        @(negedge clk);
        llclr_i = 1'b0; link_m = 1'b0;
        req_valid_i = 1'b1; op_i = OP_LL; mem_addr_i = 32'h300; bus_rdata_i = 32'h12345678;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus_ack_i = 1'b0; flush_i = 1'b0;
            if (bus_req_o === 1'b1) begin
                if (reqs == 3) bus_ack_i = 1'b1;
                reqs++;
            end
            if (done_o === 1'b1) dones++;
            if (k == 1) begin flush_i = 1'b1; req_valid_i = 1'b0; end
            #1 if (stallreq_o !== 1'b0) stall_hi++;
        end
        flush_i = 1'b0; bus_ack_i = 1'b0;
        n_cmp++;
        if ({8'(reqs), 8'(dones), 8'(stall_hi), llbit_o} !== {8'd4, 8'd0, 8'd0, 1'b0}) begin
            n_bad++; $display("FAIL flush_drain: got reqcycles=%0d dones=%0d stallhigh=%0d llbit=%b want 4 0 0 0",
                              reqs, dones, stall_hi, llbit_o);
        end
        access(OP_LHU, 32'h302, 32'h0, 0, 1'b0, 1'b0, 32'hAAAA8001, dk, rk, rc, sel, we, ba, bw, rd, fl, se);
        n_cmp++;
        if ({8'(dk), sel, rd} !== {8'd2, 4'b0011, 32'h00008001}) begin
            n_bad++; $display("FAIL after_flush: got done=%0d sel=%b rdata=%h want 2 0011 00008001", dk, sel, rd);
        end
    endtask

    task automatic test_random();
        int dk, rk, rc, se, edk, erk, erc, w, bad;
        bit berr;
        logic [3:0] op, sel, esel;
        logic we, ewe;
        logic [31:0] addr, wd, bd, ba, bw, rd, eba, ebw, erd;
        logic [2:0] fl, efl;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                llclr_i = 1'b1;
                @(negedge clk);
                llclr_i = 1'b0; link_m = 1'b0;
            end
            op = 4'($urandom_range(0, 10));
            addr = $urandom; wd = $urandom; bd = $urandom;
            if (op == 4'd10) begin
                bad = 0;
                @(negedge clk);
                req_valid_i = 1'b1; op_i = 4'($urandom_range(10, 15)); mem_addr_i = addr;
                repeat (3) begin
                    #1 if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0 || done_o !== 1'b0) bad++;
                    @(negedge clk);
                end
                req_valid_i = 1'b0;
                n_cmp++;
                if (bad != 0) begin
                    n_bad++; $display("FAIL illegal_op[%0d]: got %0d active cycles want 0", i, bad);
                end
            end else begin
                w = $urandom_range(0, 6);
                berr = ($urandom_range(0, 7) == 0);
                model(op, addr, wd, w, berr, bd, edk, erk, erc, esel, ewe, eba, ebw, erd, efl);
                access(op, addr, wd, w, berr, 1'b0, bd, dk, rk, rc, sel, we, ba, bw, rd, fl, se);
                n_cmp++;
                if ({8'(dk), 8'(rk), 8'(rc)} !== {8'(edk), 8'(erk), 8'(erc)}) begin
                    n_bad++; $display("FAIL rand_timing[%0d] op=%0d addr=%h: got done=%0d req=%0d reqcycles=%0d want %0d %0d %0d",
                                      i, op, addr, dk, rk, rc, edk, erk, erc);
                end
                n_cmp++;
                if ({sel, we, ba, bw} !== {esel, ewe, eba, ebw}) begin
                    n_bad++; $display("FAIL rand_bus[%0d] op=%0d addr=%h: got sel=%b we=%b addr=%h wdata=%h want %b %b %h %h",
                                      i, op, addr, sel, we, ba, bw, esel, ewe, eba, ebw);
                end
                n_cmp++;
                if ({rd, fl, llbit_o, 8'(se)} !== {erd, efl, link_m, 8'd0}) begin
                    n_bad++; $display("FAIL rand_result[%0d] op=%0d addr=%h: got rdata=%h flags=%b llbit=%b stallerr=%0d want %h %b %b 0",
                                      i, op, addr, rd, fl, llbit_o, se, erd, efl, link_m);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int dk, rk, rc, se;
        logic [3:0] sel; logic we; logic [31:0] ba, bw, rd; logic [2:0] fl;
        access(OP_LL, 32'h500, 32'h0, 0, 1'b0, 1'b0, 32'h0, dk, rk, rc, sel, we, ba, bw, rd, fl, se);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({llbit_o, done_o, rdata_o} !== 34'b0) begin
            n_bad++; $display("FAIL async_reset: got llbit=%b done=%b rdata=%h want 0 0 0", llbit_o, done_o, rdata_o);
        end
        @(negedge clk);
        rst = 1'b1;
        link_m = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_ll_sc();
        test_timeout();
        test_flush();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
